uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmitter, the successor to the fixed 8N1 transmitter. It serialises one character per valid/ready handshake, LSB first, with compile-time selectable data width, parity mode, stop-bit count and baud divisor. It sits between a byte-stream producer (FIFO, CPU register, loopback logic) and the board-level TX pin, and supports gap-free back-to-back frames.

## Interface
- `CLKS_PER_BIT`, default 434: clk cycles per serial bit. Legal range ≥ 2; 434 gives 115200 baud at 50 MHz.
- `DATA_BITS`, default 8: character width. Legal range 5..9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even. Value 3 is illegal and is treated as none.
- `STOP_BITS`, default 1: 1 or 2. Any other value is treated as 1.
- `clk` in, 1 bit: system clock.
- `rst_n` in, 1 bit: reset, asynchronous, active-low.
- `tx_valid` in, 1 bit: producer has a character on `tx_data`.
- `tx_data` in, `DATA_BITS` bits: character to send. Bit 0 is sent first.
- `tx_ready` out, 1 bit: block accepts a character this cycle.
- `tx` out, 1 bit: serial line, idle high.
- `busy` out, 1 bit: a frame is in progress.
- `done` out, 1 bit: one-cycle pulse at the end of each frame.

## Operation
- Frame order: start (0), `DATA_BITS` data bits LSB first, optional parity bit, `STOP_BITS` stop bits (1).
- Parity:
  - even: XOR of all data bits.
  - odd: the inverse of that XOR.
  - Computed from the latched copy of the character, not from the live `tx_data`.
- State machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on handshake (`tx_valid && tx_ready`).
  - START → DATA after 1 bit time.
  - DATA → PARITY, or directly to STOP when `PARITY` is none, after `DATA_BITS` bit times.
  - PARITY → STOP after 1 bit time.
  - STOP → IDLE after `STOP_BITS` bit times, or STOP → START if a handshake happens in the final cycle.
- Handshake:
  - `tx_ready` = 1 in IDLE, and also in the last clk cycle of the last stop bit.
  - At all other times `tx_ready` = 0.
  - `tx_data` is captured into a shift register on the handshake edge.
  - `tx_valid` without `tx_ready` is ignored. The producer holds `tx_valid` and `tx_data` stable until the handshake.
- Counters:
  - Baud counter of width `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT`-1, wraps to 0, and raises an end-of-bit strobe on the terminal count.
  - It is held at 0 in IDLE.
  - Bit index counter of width `$clog2(DATA_BITS+1)`, used in DATA and STOP; it clears on each state change.
- Outputs:
  - `busy` = 1 in every state except IDLE.
  - `done` = 1 for exactly the final cycle of the last stop bit, including back-to-back frames.
- `tx` is registered and glitch-free. It is 1 in IDLE.
- Reset value of every output: `tx` = 1, `tx_ready` = 1, `busy` = 0, `done` = 0. The FSM resets to IDLE and all counters reset to 0.
- Reset mid-frame: `tx` returns to 1 asynchronously, the partial frame is abandoned, and no `done` pulse is produced.

## Timing
- Latency: handshake on edge N → `tx` = 0 from edge N+1.
- Each bit lasts exactly `CLKS_PER_BIT` cycles.
- Frame length F = (1 + `DATA_BITS` + (`PARITY`≠0) + `STOP_BITS`) × `CLKS_PER_BIT` cycles.
- `done` is high during cycle N+F. It coincides with `tx_ready` = 1.
- Back-to-back: a handshake in cycle N+F makes the next start bit begin at edge N+F+1. There are zero idle cycles between frames.
- Without a new handshake, the block enters IDLE at edge N+F+1 with `tx` = 1 and `busy` = 0.

## Structure
- Package `uart_pkg` holds:
  - the parity encodings `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`;
  - the FSM state typedef;
  - a shared function for the frame-length calculation.
- Sub-module `uart_baud_gen`: the baud counter plus the end-of-bit strobe, with an enable input and a `CLKS_PER_BIT` parameter. It is reused by the future receiver.
- The FSM, shift register, parity logic and output registers live in `uart_tx_frame`.

## Test plan
- 8N1, `CLKS_PER_BIT`=4: send 0xA5.
  - `tx` = 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles.
  - `done` pulses at cycle 40 after the handshake edge.
- 8E1 and 8O1, `CLKS_PER_BIT`=4: send 0xA5.
  - Parity bit (frame bit 9) is 0 for even and 1 for odd.
  - F = 44 cycles.
- 7N2, `CLKS_PER_BIT`=3: send 0x7F.
  - Sequence is 0, seven 1s, then two stop 1s.
  - `tx_ready` is low for cycles 1..29 and high in cycle 30 together with `done`.
- Back-to-back 8N1: `tx_valid` held high with 0x00 then 0xFF.
  - Second start bit follows the first stop bit with no idle cycle.
  - Two `done` pulses exactly 40 cycles apart.
- Reset mid-frame: assert `rst_n`=0 during data bit 3.
  - `tx` = 1 immediately, `busy` = 0, no `done` pulse.
  - After release, a new 0x3C frame is sent correctly.
- `tx_valid` pulsed while `busy`=1: ignored. The in-flight frame is unchanged and no extra frame is sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: parity encodings, FSM state
// type and the frame-length helper used by both the transmitter and
// the future receiver.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Illegal parity selection (3 or anything unknown) falls back to none.
    function automatic logic [1:0] par_mode(input int p);
        logic [1:0] m;
        case (p)
            1:       m = PAR_ODD;
            2:       m = PAR_EVEN;
            default: m = PAR_NONE;
        endcase
        return m;
    endfunction

    // Only 2 selects two stop bits; every other value means one.
    function automatic int unsigned stop_count(input int s);
        int unsigned n;
        case (s)
            2:       n = 32'd2;
            default: n = 32'd1;
        endcase
        return n;
    endfunction

    // Frame length in clk cycles: start + data + optional parity + stops.
    function automatic int unsigned frame_cycles(input int unsigned cpb,
                                                 input int unsigned data_bits,
                                                 input int unsigned par_on,
                                                 input int unsigned stop_bits);
        return (32'd1 + data_bits + par_on + stop_bits) * cpb;
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Producer-to-transmitter character handshake.
//   tx_valid : producer has a character on tx_data
//   tx_data  : character, bit 0 transmitted first
//   tx_ready : transmitter accepts the character this cycle
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Baud counter with end-of-bit strobe.
//   clk, rst_n : clock, asynchronous active-low reset
//   en_i       : count while high, held at 0 while low
//   cnt_o      : current position inside the bit, 0..CLKS_PER_BIT-1
//   tick_o     : high on the terminal count (last cycle of a bit)
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434,
    localparam int CNT_W = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tick_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Bit-time counter: wraps on the terminal count, parked at 0 when disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en_i) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt_o  = cnt_q;
    assign tick_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: one character per handshake, LSB first,
// optional parity, one or two stop bits, gap-free back-to-back frames.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of the character handshake
//   tx         : serial line, idle high, registered
//   busy       : a frame is in progress
//   done       : one-cycle pulse in the final cycle of the last stop bit
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_frame_if.slave   bus,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0]  PAR_MODE = par_mode(PARITY);
    localparam int unsigned STOP_N   = stop_count(STOP_BITS);
    localparam int          CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int          BIT_W    = $clog2(DATA_BITS + 1);

    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_N - 1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
    // Count one cycle before the terminal count: outputs registered there
    // become valid exactly in the final cycle of the bit.
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(CLKS_PER_BIT - 2);

    // XOR is invariant under rotation, so the rotating shift register can be
    // used at any point of the frame as the latched copy of the character.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        logic p;
        if (PAR_MODE == PAR_ODD) begin
            p = ~(^d);
        end else begin
            p = ^d;
        end
        return p;
    endfunction

    tx_state_e            state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [BIT_W-1:0]     bit_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 tx_ready_q;

    logic [CNT_W-1:0]     cnt_s;
    logic                 tick_s;
    logic                 baud_en_s;
    logic                 hs_s;
    logic                 last_stop_s;
    logic                 pre_final_s;
    logic                 next_idle_s;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (baud_en_s),
        .cnt_o  (cnt_s),
        .tick_o (tick_s)
    );

    // Handshake and end-of-frame decode feeding the registered outputs.
    always_comb begin
        baud_en_s   = (state_q != ST_IDLE);
        hs_s        = bus.tx_valid && tx_ready_q;
        last_stop_s = (state_q == ST_STOP) && (bit_q == STOP_LAST);
        pre_final_s = last_stop_s && (cnt_s == CNT_PRE);
        next_idle_s = ((state_q == ST_IDLE) || (last_stop_s && tick_s)) && !hs_s;
    end

    // Frame FSM with shift register, bit index and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_q      <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_ready_q <= 1'b1;
        end else begin
            done_q     <= pre_final_s;
            tx_ready_q <= pre_final_s || next_idle_s;
            busy_q     <= !next_idle_s;

            case (state_q)
                ST_IDLE: begin
                    if (hs_s) begin
                        shift_q <= bus.tx_data;
                        bit_q   <= '0;
                        tx_q    <= 1'b0;
                        state_q <= ST_START;
                    end else begin
                        tx_q    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        tx_q    <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        // Rotate so the register holds the original character again.
                        shift_q <= {shift_q[0], shift_q[DATA_BITS-1:1]};
                        if (bit_q == DATA_LAST) begin
                            bit_q <= '0;
                            if (PAR_MODE != PAR_NONE) begin
                                tx_q    <= parity_bit(shift_q);
                                state_q <= ST_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            bit_q <= bit_q + BIT_ONE;
                            tx_q  <= shift_q[1];
                        end
                    end else begin
                        tx_q <= tx_q;
                    end
                end
                ST_PARITY: begin
                    if (tick_s) begin
                        bit_q   <= '0;
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                    end else begin
                        tx_q    <= tx_q;
                    end
                end
                ST_STOP: begin
                    if (tick_s) begin
                        if (bit_q != STOP_LAST) begin
                            bit_q <= bit_q + BIT_ONE;
                            tx_q  <= 1'b1;
                        end else if (hs_s) begin
                            // Back-to-back: next start bit follows without an idle cycle.
                            shift_q <= bus.tx_data;
                            bit_q   <= '0;
                            tx_q    <= 1'b0;
                            state_q <= ST_START;
                        end else begin
                            bit_q   <= '0;
                            tx_q    <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        tx_q <= 1'b1;
                    end
                end
                default: begin
                    bit_q   <= '0;
                    tx_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_ready = tx_ready_q;
    assign tx           = tx_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame in four configurations:
//   0: 8N1 CLKS_PER_BIT=4   1: 8E1 CLKS_PER_BIT=4
//   2: 8O1 CLKS_PER_BIT=4   3: 7N2 CLKS_PER_BIT=3
// Cycle k of a frame is the k-th cycle after the handshake edge; outputs
// are sampled on the falling edge.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] valid_r;
    logic [8:0] data_r;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    uart_tx_frame_if #(.DATA_BITS(8)) if0 ();
    uart_tx_frame_if #(.DATA_BITS(8)) if1 ();
    uart_tx_frame_if #(.DATA_BITS(8)) if2 ();
    uart_tx_frame_if #(.DATA_BITS(7)) if3 ();

    assign if0.tx_valid = valid_r[0];
    assign if1.tx_valid = valid_r[1];
    assign if2.tx_valid = valid_r[2];
    assign if3.tx_valid = valid_r[3];
    assign if0.tx_data  = data_r[7:0];
    assign if1.tx_data  = data_r[7:0];
    assign if2.tx_data  = data_r[7:0];
    assign if3.tx_data  = data_r[6:0];

    logic tx0, tx1, tx2, tx3;
    logic busy0, busy1, busy2, busy3;
    logic done0, done1, done2, done3;
    logic [3:0] tx_w, busy_w, done_w, rdy_w;

    assign tx_w   = {tx3, tx2, tx1, tx0};
    assign busy_w = {busy3, busy2, busy1, busy0};
    assign done_w = {done3, done2, done1, done0};
    assign rdy_w  = {if3.tx_ready, if2.tx_ready, if1.tx_ready, if0.tx_ready};

    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave), .tx(tx0), .busy(busy0), .done(done0));
    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave), .tx(tx1), .busy(busy1), .done(done1));
    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave), .tx(tx2), .busy(busy2), .done(done2));
    uart_tx_frame #(.CLKS_PER_BIT(3), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst_n(rst_n), .bus(if3.slave), .tx(tx3), .busy(busy3), .done(done3));

    task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // Present a character while idle; returns just after the capture edge.
    task automatic start_hs(input int cfg, input logic [8:0] d);
        @(negedge clk);
        valid_r[cfg] = 1'b1;
        data_r       = d;
        @(posedge clk);
        #1;
    endtask

    // Checks every cycle of one frame. bits[0] is the first bit on the line.
    // nxt_v keeps tx_valid high with nxt_d for a back-to-back frame;
    // pulse_k raises tx_valid for one cycle mid-frame.
    task automatic check_frame(input int cfg, input logic [11:0] bits, input int nbits,
                               input int cpb, input logic nxt_v, input logic [8:0] nxt_d,
                               input int pulse_k);
        int f;
        f = nbits * cpb;
        valid_r[cfg] = nxt_v;
        if (nxt_v) data_r = nxt_d;
        for (int k = 1; k <= f; k++) begin
            @(negedge clk);
            chk("tx",    k, tx_w[cfg],   bits[(k-1)/cpb]);
            chk("done",  k, done_w[cfg], (k == f));
            chk("ready", k, rdy_w[cfg],  (k == f));
            chk("busy",  k, busy_w[cfg], 1'b1);
            if (pulse_k > 0 && k == pulse_k) begin
                valid_r[cfg] = 1'b1;
                data_r       = 9'h1FF;
            end else if (pulse_k > 0 && k == pulse_k + 1) begin
                valid_r[cfg] = 1'b0;
            end
        end
    endtask

    task automatic check_idle(input int cfg, input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            chk("idle_tx",    k, tx_w[cfg],   1'b1);
            chk("idle_busy",  k, busy_w[cfg], 1'b0);
            chk("idle_ready", k, rdy_w[cfg],  1'b1);
            chk("idle_done",  k, done_w[cfg], 1'b0);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        valid_r = 4'b0000;
        data_r  = 9'h000;

        // Reset values on every configuration.
        #12;
        for (int c = 0; c < 4; c++) begin
            chk("rst_tx",    c, tx_w[c],   1'b1);
            chk("rst_ready", c, rdy_w[c],  1'b1);
            chk("rst_busy",  c, busy_w[c], 1'b0);
            chk("rst_done",  c, done_w[c], 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_idle(0, 2);

        // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1 ; F = 40
        start_hs(0, 9'h0A5);
        check_frame(0, {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 4, 1'b0, 9'h000, 0);
        check_idle(0, 2);

        // 8E1 0xA5: four ones, even parity bit 0 ; F = 44
        start_hs(1, 9'h0A5);
        check_frame(1, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 4, 1'b0, 9'h000, 0);
        check_idle(1, 2);

        // 8O1 0xA5: odd parity bit 1 ; F = 44
        start_hs(2, 9'h0A5);
        check_frame(2, {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, 4, 1'b0, 9'h000, 0);
        check_idle(2, 2);

        // 7N2 0x7F, CLKS_PER_BIT=3: 0, seven 1s, two stop 1s ; F = 30
        start_hs(3, 9'h07F);
        check_frame(3, {2'b00, 2'b11, 7'h7F, 1'b0}, 10, 3, 1'b0, 9'h000, 0);
        check_idle(3, 2);

        // Back-to-back 8N1: 0x00 then 0xFF with tx_valid held high.
        start_hs(0, 9'h000);
        check_frame(0, {2'b00, 1'b1, 8'h00, 1'b0}, 10, 4, 1'b1, 9'h0FF, 0);
        @(posedge clk);
        #1;
        check_frame(0, {2'b00, 1'b1, 8'hFF, 1'b0}, 10, 4, 1'b0, 9'h000, 0);
        check_idle(0, 2);

        // Reset during data bit 3 (frame bit 4, cycles 17..20).
        start_hs(0, 9'h0A5);
        valid_r[0] = 1'b0;
        repeat (18) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_tx",    18, tx_w[0],   1'b1);
        chk("midrst_busy",  18, busy_w[0], 1'b0);
        chk("midrst_done",  18, done_w[0], 1'b0);
        chk("midrst_ready", 18, rdy_w[0],  1'b1);
        @(negedge clk);
        chk("midrst_done2", 19, done_w[0], 1'b0);
        rst_n = 1'b1;
        check_idle(0, 3);
        start_hs(0, 9'h03C);
        check_frame(0, {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 4, 1'b0, 9'h000, 0);
        check_idle(0, 2);

        // tx_valid pulsed mid-frame is ignored; no extra frame afterwards.
        start_hs(0, 9'h05A);
        check_frame(0, {2'b00, 1'b1, 8'h5A, 1'b0}, 10, 4, 1'b0, 9'h000, 12);
        check_idle(0, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
